// File: rtl/nipcb_pkg.sv
// Shared NIPCB types: arbiter FSM states, owner and SPI slave encodings, DAC frame layout.
// Combinational definitions only; no latency or flow control of its own.
package nipcb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_MASK  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic OWNER_STIM = 1'b0;
  localparam logic OWNER_REC  = 1'b1;

  localparam int SPI_SLAVE_DAC = 0;
  localparam int SPI_SLAVE_ADC = 1;

  localparam int SPI_FRAME_BW = 16;

  // DAC frame is {DAC_PAD_HI zeros, word, DAC_PAD_LO zeros}
  localparam int DAC_PAD_HI = 1;
  localparam int DAC_PAD_LO = 5;

endpackage

// File: rtl/nipcb_spi_arbiter_if.sv
// Bundle of requester handshakes, spi_core connections and status between the arbiter and its neighbours.
// master = arbiter side, slave = sequencers plus spi_core side.
interface nipcb_spi_arbiter_if
  import nipcb_pkg::*;
#(
  parameter int STIM_BW = 10,
  parameter int REC_BW  = 14
);
  logic                    stim_req;
  logic [STIM_BW-1:0]      stim_data;
  logic                    stim_ack;
  logic                    rec_req;
  logic                    rec_ack;
  logic [REC_BW-1:0]       rec_data;
  logic [SPI_FRAME_BW-1:0] spi_odata;
  logic [1:0]              spi_send;
  logic [1:0]              spi_recv;
  logic [REC_BW-1:0]       spi_idata;
  logic                    spi_ready;
  logic                    busy;
  logic                    owner;
  logic                    timeout_err;
  logic                    clear_err;

  modport master (
    input  stim_req, stim_data, rec_req, spi_idata, spi_ready, clear_err,
    output stim_ack, rec_ack, rec_data, spi_odata, spi_send, spi_recv,
           busy, owner, timeout_err
  );

  modport slave (
    output stim_req, stim_data, rec_req, spi_idata, spi_ready, clear_err,
    input  stim_ack, rec_ack, rec_data, spi_odata, spi_send, spi_recv,
           busy, owner, timeout_err
  );

endinterface

// File: rtl/nipcb_spi_arbiter.sv
// Shares spi_core between DAC writes (fixed priority, streak-limited) and ADC reads, with timeout.
// Grant at N -> send/recv pulse at N+1, ack one cycle after first spi_ready in WAIT; requesters held via req/ack.
module nipcb_spi_arbiter
  import nipcb_pkg::*;
#(
  parameter int STIM_BW    = 10,
  parameter int REC_BW     = 14,
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 1024
) (
  input logic clk,
  input logic rst,
  nipcb_spi_arbiter_if.master bus
);

  localparam int STREAK_W = $clog2(MAX_STREAK + 1);
  localparam int TMO_W    = $clog2(TIMEOUT + 1);

  state_t                  state;
  state_t                  state_nxt;
  logic                    owner_q;
  logic [STREAK_W-1:0]     streak;
  logic [TMO_W-1:0]        tmo_cnt;
  logic [SPI_FRAME_BW-1:0] odata_q;
  logic [REC_BW-1:0]       rec_data_q;
  logic                    timeout_err_q;
  logic [STIM_BW-1:0]      stim_word;
  logic                    grant;
  logic                    grant_rec;
  logic                    streak_full;
  logic                    tmo_hit;
  logic                    tmo_run;

  assign stim_word   = bus.stim_data;
  assign grant       = (state == ST_IDLE) && bus.spi_ready && (bus.stim_req || bus.rec_req);
  assign streak_full = (streak == STREAK_W'(MAX_STREAK));
  assign grant_rec   = bus.rec_req && (!bus.stim_req || streak_full);
  assign tmo_hit     = (state == ST_WAIT) && !bus.spi_ready && (tmo_cnt == TMO_W'(TIMEOUT));
  assign tmo_run     = (state == ST_ISSUE) || (state == ST_MASK) || ((state == ST_WAIT) && !tmo_hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (grant) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_MASK;
      ST_MASK:  state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (bus.spi_ready)  state_nxt = ST_DONE;
        else if (tmo_hit)   state_nxt = ST_IDLE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy     = (state != ST_IDLE);
    bus.stim_ack = (state == ST_DONE) && (owner_q == OWNER_STIM);
    bus.rec_ack  = (state == ST_DONE) && (owner_q == OWNER_REC);
    bus.spi_send = '0;
    bus.spi_recv = '0;
    if (state == ST_ISSUE) begin
      if (owner_q == OWNER_STIM) bus.spi_send[SPI_SLAVE_DAC] = 1'b1;
      else                       bus.spi_recv[SPI_SLAVE_ADC] = 1'b1;
    end
  end

  assign bus.owner       = owner_q;
  assign bus.spi_odata   = odata_q;
  assign bus.rec_data    = rec_data_q;
  assign bus.timeout_err = timeout_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q       <= OWNER_STIM;
      odata_q       <= '0;
      streak        <= '0;
      tmo_cnt       <= '0;
      rec_data_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (grant) begin
        owner_q <= grant_rec ? OWNER_REC : OWNER_STIM;
        odata_q <= grant_rec ? '0 : {{DAC_PAD_HI{1'b0}}, stim_word, {DAC_PAD_LO{1'b0}}};
        // Streak only grows while a read is actually being held off
        if (grant_rec || !bus.rec_req) streak <= '0;
        else if (!streak_full)         streak <= streak + STREAK_W'(1);
      end
      if (grant)        tmo_cnt <= '0;
      else if (tmo_run) tmo_cnt <= tmo_cnt + TMO_W'(1);
      if ((state == ST_WAIT) && bus.spi_ready && (owner_q == OWNER_REC))
        rec_data_q <= bus.spi_idata;
      if (tmo_hit)            timeout_err_q <= 1'b1;
      else if (bus.clear_err) timeout_err_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nipcb_spi_arbiter.sv
// Directed bench: spi_core model drives spi_ready, scoreboard queue checks every send/recv pulse and ack.
module tb_nipcb_spi_arbiter;

  localparam int TIMEOUT = 1024;

  logic clk;
  logic rst;
  int   cyc;
  int   n_pass;
  int   n_total;
  int   busy_len;
  int   rise_cyc;
  int   ack_cnt;

  typedef struct {
    logic [5:0]  sig;   // {spi_send, spi_recv, stim_ack, rec_ack}
    logic [15:0] data;
  } ev_t;
  ev_t exp_q[$];

  localparam logic [5:0] SIG_IS = 6'b01_00_0_0;
  localparam logic [5:0] SIG_IR = 6'b00_10_0_0;
  localparam logic [5:0] SIG_AS = 6'b00_00_1_0;
  localparam logic [5:0] SIG_AR = 6'b00_00_0_1;

  nipcb_spi_arbiter_if #(.STIM_BW(10), .REC_BW(14)) bus ();

  nipcb_spi_arbiter #(
    .STIM_BW(10), .REC_BW(14), .MAX_STREAK(4), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic push(input logic [5:0] sig, input logic [15:0] data);
    ev_t e;
    e.sig  = sig;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // spi_core model: busy for busy_len cycles after each send/recv pulse
  initial begin
    bus.spi_ready = 1'b1;
    rise_cyc = 0;
    forever begin
      @(negedge clk);
      if (!rst && (bus.spi_send != 2'b00 || bus.spi_recv != 2'b00)) begin
        bus.spi_ready = 1'b0;
        repeat (busy_len) @(negedge clk);
        bus.spi_ready = 1'b1;
        rise_cyc = cyc;
      end
    end
  end

  // Scoreboard monitor
  initial begin
    ack_cnt = 0;
    forever begin
      logic [5:0]  sig;
      logic [15:0] data;
      ev_t         e;
      @(negedge clk);
      sig = {bus.spi_send, bus.spi_recv, bus.stim_ack, bus.rec_ack};
      if (!rst && sig != 6'b0) begin
        data = 16'h0;
        if (sig == SIG_IS) data = bus.spi_odata;
        if (sig == SIG_AR) data = {2'b00, bus.rec_data};
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_event: got sig %b data %h expected none (cycle %0d)", sig, data, cyc);
        end else begin
          e = exp_q.pop_front();
          check("event_sig", {26'b0, sig}, {26'b0, e.sig});
          check("event_data", {16'b0, data}, {16'b0, e.data});
        end
        if (bus.stim_ack || bus.rec_ack) begin
          ack_cnt++;
          check("ack_after_ready", cyc - rise_cyc, 1);
        end
      end
    end
  end

  task automatic wait_issue(input string nm, output int c);
    int found;
    found = 0;
    c = 0;
    for (int i = 0; i < 3000 && found == 0; i++) begin
      @(negedge clk);
      if (bus.spi_send != 2'b00 || bus.spi_recv != 2'b00) begin
        found = 1;
        c = cyc;
      end
    end
    check(nm, found, 1);
  endtask

  task automatic wait_ack(input string nm);
    int found;
    found = 0;
    for (int i = 0; i < 3000 && found == 0; i++) begin
      @(negedge clk);
      if (bus.stim_ack || bus.rec_ack) found = 1;
    end
    check(nm, found, 1);
  endtask

  task automatic wait_ready(input string nm);
    int found;
    found = 0;
    for (int i = 0; i < 3000 && found == 0; i++) begin
      @(negedge clk);
      if (bus.spi_ready) found = 1;
    end
    check(nm, found, 1);
  endtask

  initial begin
    int t0;
    int t1;
    int seen;
    int found;
    int acks0;
    n_pass        = 0;
    n_total       = 0;
    busy_len      = 4;
    rst           = 1'b1;
    bus.stim_req  = 1'b0;
    bus.stim_data = '0;
    bus.rec_req   = 1'b0;
    bus.spi_idata = '0;
    bus.clear_err = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", bus.busy, 0);
    check("rst_owner", bus.owner, 0);
    check("rst_acks", {bus.stim_ack, bus.rec_ack}, 0);
    check("rst_spi_pulses", {bus.spi_send, bus.spi_recv}, 0);
    check("rst_spi_odata", bus.spi_odata, 0);
    check("rst_rec_data", bus.rec_data, 0);
    check("rst_timeout_err", bus.timeout_err, 0);
    rst = 1'b0;
    @(negedge clk);

    // Stim only, spi busy for 20 cycles
    busy_len = 20;
    push(SIG_IS, 16'h1FE0);
    push(SIG_AS, 16'h0);
    bus.stim_req  = 1'b1;
    bus.stim_data = 10'h0FF;
    wait_issue("stim_issue_seen", t0);
    check("stim_owner", bus.owner, 0);
    wait_ack("stim_ack_seen");
    bus.stim_req = 1'b0;
    repeat (3) @(negedge clk);
    check("stim_odata_held", bus.spi_odata, 16'h1FE0);
    check("stim_idle_after", bus.busy, 0);

    // Rec only
    busy_len = 4;
    bus.spi_idata = 14'h1234;
    push(SIG_IR, 16'h0);
    push(SIG_AR, 16'h1234);
    bus.rec_req = 1'b1;
    wait_issue("rec_issue_seen", t0);
    check("rec_owner", bus.owner, 1);
    wait_ack("rec_ack_seen");
    bus.rec_req = 1'b0;
    bus.spi_idata = 14'h0AAA;
    repeat (4) @(negedge clk);
    check("rec_data_held", bus.rec_data, 14'h1234);

    // Both held: stim x4, rec x1, twice
    bus.stim_data = 10'h155;
    bus.spi_idata = 14'h2ABC;
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < 4; s++) begin
        push(SIG_IS, 16'h2AA0);
        push(SIG_AS, 16'h0);
      end
      push(SIG_IR, 16'h0);
      push(SIG_AR, 16'h2ABC);
    end
    bus.stim_req = 1'b1;
    bus.rec_req  = 1'b1;
    seen = 0;
    for (int i = 0; i < 2000 && seen < 10; i++) begin
      @(negedge clk);
      if (bus.stim_ack || bus.rec_ack) seen++;
    end
    bus.stim_req = 1'b0;
    bus.rec_req  = 1'b0;
    check("both_ack_count", seen, 10);
    check("both_queue_drained", exp_q.size(), 0);
    repeat (3) @(negedge clk);

    // Timeout: spi_ready stays low past TIMEOUT, then retry succeeds
    busy_len = 1100;
    push(SIG_IS, 16'h7860);
    bus.stim_req  = 1'b1;
    bus.stim_data = 10'h3C3;
    wait_issue("tmo_issue_seen", t0);
    found = 0;
    t1 = 0;
    acks0 = ack_cnt;
    for (int i = 0; i < 1200 && found == 0; i++) begin
      @(negedge clk);
      if (bus.timeout_err) begin
        found = 1;
        t1 = cyc;
      end
    end
    check("tmo_flag_seen", found, 1);
    check("tmo_flag_cycle", t1 - t0, TIMEOUT + 1);
    check("tmo_back_idle", bus.busy, 0);
    check("tmo_no_ack", ack_cnt - acks0, 0);
    busy_len = 5;
    push(SIG_IS, 16'h7860);
    push(SIG_AS, 16'h0);
    wait_ack("tmo_retry_ack");
    bus.stim_req = 1'b0;
    check("tmo_flag_sticky", bus.timeout_err, 1);
    bus.clear_err = 1'b1;
    @(negedge clk);
    bus.clear_err = 1'b0;
    check("tmo_flag_cleared", bus.timeout_err, 0);
    repeat (3) @(negedge clk);

    // Reset in WAIT aborts without ack
    busy_len = 30;
    push(SIG_IR, 16'h0);
    bus.rec_req = 1'b1;
    wait_issue("rst_issue_seen", t0);
    repeat (5) @(negedge clk);
    check("rst_mid_busy_before", bus.busy, 1);
    rst = 1'b1;
    bus.rec_req = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_outputs", {bus.stim_ack, bus.rec_ack, bus.spi_send, bus.spi_recv, bus.owner, bus.timeout_err}, 0);
    check("rst_mid_rec_data", bus.rec_data, 0);
    check("rst_mid_odata", bus.spi_odata, 0);
    rst = 1'b0;
    acks0 = ack_cnt;
    wait_ready("rst_ready_back");
    repeat (5) @(negedge clk);
    check("rst_mid_no_ack", ack_cnt - acks0, 0);

    // Drop stim_req during MASK; transaction still completes once
    busy_len = 6;
    push(SIG_IS, 16'h0020);
    push(SIG_AS, 16'h0);
    bus.stim_req  = 1'b1;
    bus.stim_data = 10'h001;
    wait_issue("drop_issue_seen", t0);
    @(negedge clk);
    bus.stim_req = 1'b0;
    acks0 = ack_cnt;
    wait_ack("drop_ack_seen");
    repeat (20) @(negedge clk);
    check("drop_single_ack", ack_cnt - acks0, 1);
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
